mcs_io_wb_bridge: RTL and testbench

- Bridges the MicroBlaze MCS IO bus to the WISHBONE MMIO fabric. It sits directly upstream of the wishbone_if master modport.
- Each MCS IO read or write strobe becomes exactly one classic single WISHBONE cycle.
- It returns read data and IO_Ready to the MCS.
- A watchdog terminates cycles that no slave acknowledges, so the CPU never hangs.

---
 rtl/mcs_io_wb_bridge.sv | 130 +++++++++++++
 tb/tb_mcs_io_wb_bridge.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mcs_io_wb_bridge.sv
// MicroBlaze MCS IO bus to classic single-cycle WISHBONE master bridge.
// Each accepted IO strobe becomes one CYC/STB cycle, ended by ACK or by a watchdog timeout.
module mcs_io_wb_bridge #(
   parameter int                    ADDR_WIDTH     = 30,
   parameter int                    DATA_WIDTH     = 32,
   parameter int                    TIMEOUT_CYCLES = 255,
   parameter logic [DATA_WIDTH-1:0] TIMEOUT_DATA   = 32'hDEAD_BEEF
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  IO_Addr_Strobe,
   input  logic                  IO_Read_Strobe,
   input  logic                  IO_Write_Strobe,
   input  logic [31:0]           IO_Address,
   input  logic [3:0]            IO_Byte_Enable,
   input  logic [31:0]           IO_Write_Data,
   output logic [31:0]           IO_Read_Data,
   output logic                  IO_Ready,
   output logic [ADDR_WIDTH-1:0] WB_ADDR,
   output logic [DATA_WIDTH-1:0] WB_DAT_W,
   input  logic [DATA_WIDTH-1:0] WB_DAT_R,
   output logic                  WB_CYC,
   output logic                  WB_STB,
   output logic                  WB_WE,
   input  logic                  WB_ACK,
   output logic                  TIMEOUT_FLAG,
   output logic                  PARTIAL_WR_FLAG,
   input  logic                  FLAG_CLR
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_BUS,
      ST_DONE
   } state_t;

   localparam logic [15:0] LAST_WAIT = 16'(TIMEOUT_CYCLES - 1);

   state_t      state;
   state_t      state_nxt;
   logic [15:0] wait_cnt;
   logic        start;
   logic        acked;
   logic        timed_out;
   logic        partial_wr;

   // The byte-lane bits below the word address never reach the bus.
   logic unused_addr_bits;
   assign unused_addr_bits = ^IO_Address;

   assign partial_wr = IO_Write_Strobe && (IO_Byte_Enable != 4'hF);

   always_comb begin
      // NOTE: every combinational output gets a default first so no path infers a latch.
      state_nxt = state;
      start     = 1'b0;
      acked     = 1'b0;
      timed_out = 1'b0;
      case (state)
         ST_IDLE: begin
            if (IO_Addr_Strobe && (IO_Read_Strobe || IO_Write_Strobe)) begin
               start     = 1'b1;
               state_nxt = ST_BUS;
            end
         end
         ST_BUS: begin
            if (WB_ACK) begin
               acked     = 1'b1;
               state_nxt = ST_DONE;
            end else if (wait_cnt == LAST_WAIT) begin
               timed_out = 1'b1;
               state_nxt = ST_DONE;
            end
         end
         ST_DONE: state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) state <= ST_IDLE;
      else      state <= state_nxt;
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         WB_ADDR         <= '0;
         WB_DAT_W        <= '0;
         WB_CYC          <= 1'b0;
         WB_STB          <= 1'b0;
         WB_WE           <= 1'b0;
         IO_Ready        <= 1'b0;
         IO_Read_Data    <= '0;
         TIMEOUT_FLAG    <= 1'b0;
         PARTIAL_WR_FLAG <= 1'b0;
         wait_cnt        <= '0;
      end else begin
         if (start) begin
            WB_ADDR  <= IO_Address[ADDR_WIDTH+1:2];
            WB_DAT_W <= IO_Write_Data;
            WB_WE    <= IO_Write_Strobe;
            WB_CYC   <= 1'b1;
            WB_STB   <= 1'b1;
            wait_cnt <= '0;
         end else if (state == ST_BUS && !acked && !timed_out) begin
            wait_cnt <= wait_cnt + 16'd1;
         end

         if (acked || timed_out) begin
            WB_CYC   <= 1'b0;
            WB_STB   <= 1'b0;
            WB_WE    <= 1'b0;
            IO_Ready <= 1'b1;
         end
         if (acked && !WB_WE)     IO_Read_Data <= WB_DAT_R;
         if (timed_out && !WB_WE) IO_Read_Data <= TIMEOUT_DATA;

         if (state == ST_DONE) IO_Ready <= 1'b0;

         // A set event on the same edge as FLAG_CLR wins.
         if (timed_out)     TIMEOUT_FLAG <= 1'b1;
         else if (FLAG_CLR) TIMEOUT_FLAG <= 1'b0;

         if (start && partial_wr) PARTIAL_WR_FLAG <= 1'b1;
         else if (FLAG_CLR)       PARTIAL_WR_FLAG <= 1'b0;
      end
   end

endmodule

// File: tb/tb_mcs_io_wb_bridge.sv
// Randomized self-checking bench for mcs_io_wb_bridge; the bench plays both the MCS and the slave.
module tb_mcs_io_wb_bridge;

   localparam int          AW      = 30;
   localparam int          DW      = 32;
   localparam int          TO      = 8;
   localparam logic [31:0] TO_DATA = 32'hDEAD_BEEF;

   logic          CLK = 1'b0;
   logic          RST = 1'b1;
   logic          IO_Addr_Strobe = 1'b0;
   logic          IO_Read_Strobe = 1'b0;
   logic          IO_Write_Strobe = 1'b0;
   logic [31:0]   IO_Address = '0;
   logic [3:0]    IO_Byte_Enable = '0;
   logic [31:0]   IO_Write_Data = '0;
   logic [31:0]   IO_Read_Data;
   logic          IO_Ready;
   logic [AW-1:0] WB_ADDR;
   logic [DW-1:0] WB_DAT_W;
   logic [DW-1:0] WB_DAT_R = '0;
   logic          WB_CYC;
   logic          WB_STB;
   logic          WB_WE;
   logic          WB_ACK = 1'b0;
   logic          TIMEOUT_FLAG;
   logic          PARTIAL_WR_FLAG;
   logic          FLAG_CLR = 1'b0;

   mcs_io_wb_bridge #(
      .ADDR_WIDTH    (AW),
      .DATA_WIDTH    (DW),
      .TIMEOUT_CYCLES(TO),
      .TIMEOUT_DATA  (TO_DATA)
   ) dut (
      .CLK            (CLK),
      .RST            (RST),
      .IO_Addr_Strobe (IO_Addr_Strobe),
      .IO_Read_Strobe (IO_Read_Strobe),
      .IO_Write_Strobe(IO_Write_Strobe),
      .IO_Address     (IO_Address),
      .IO_Byte_Enable (IO_Byte_Enable),
      .IO_Write_Data  (IO_Write_Data),
      .IO_Read_Data   (IO_Read_Data),
      .IO_Ready       (IO_Ready),
      .WB_ADDR        (WB_ADDR),
      .WB_DAT_W       (WB_DAT_W),
      .WB_DAT_R       (WB_DAT_R),
      .WB_CYC         (WB_CYC),
      .WB_STB         (WB_STB),
      .WB_WE          (WB_WE),
      .WB_ACK         (WB_ACK),
      .TIMEOUT_FLAG   (TIMEOUT_FLAG),
      .PARTIAL_WR_FLAG(PARTIAL_WR_FLAG),
      .FLAG_CLR       (FLAG_CLR)
   );

   always #5 CLK = ~CLK;

   int          n_checks = 0;
   int          n_pass   = 0;
   logic [31:0] exp_rd   = '0;
   bit          exp_to   = 1'b0;
   bit          exp_pw   = 1'b0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
      n_checks++;
      if (got === want) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, want);
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic clear_strobes();
      IO_Addr_Strobe  = 1'b0;
      IO_Read_Strobe  = 1'b0;
      IO_Write_Strobe = 1'b0;
      FLAG_CLR        = 1'b0;
   endtask

   // One IDLE cycle with noise that must be ignored: bare address strobes and stray ACKs.
   task automatic idle_cycle(input bit clr);
      IO_Addr_Strobe  = 1'($urandom);
      IO_Read_Strobe  = 1'b0;
      IO_Write_Strobe = 1'b0;
      IO_Address      = $urandom;
      IO_Write_Data   = $urandom;
      WB_ACK          = 1'($urandom);
      WB_DAT_R        = $urandom;
      FLAG_CLR        = clr;
      tick();
      if (clr) begin
         exp_to = 1'b0;
         exp_pw = 1'b0;
      end
      clear_strobes();
      WB_ACK = 1'b0;
      check("idle", {WB_CYC, WB_STB, IO_Ready, TIMEOUT_FLAG, PARTIAL_WR_FLAG},
            {1'b0, 1'b0, 1'b0, exp_to, exp_pw});
      check("idle_rdata", IO_Read_Data, exp_rd);
   endtask

   // waits < 0 means the slave never acknowledges.
   task automatic access(input bit rd, input bit wr, input logic [31:0] addr, input logic [3:0] be,
                         input logic [31:0] wdata, input int waits, input logic [31:0] rdata,
                         input bit busy, input bit clr_start, input bit clr_end);
      bit timeout  = !(waits >= 0 && waits < TO);
      int exp_high = timeout ? TO : waits + 1;
      bit partial  = wr && (be != 4'hF);
      int high     = 0;
      int readies  = 0;
      bit stable   = 1'b1;

      IO_Addr_Strobe  = 1'b1;
      IO_Read_Strobe  = rd;
      IO_Write_Strobe = wr;
      IO_Address      = addr;
      IO_Byte_Enable  = be;
      IO_Write_Data   = wdata;
      FLAG_CLR        = clr_start;
      tick();
      if (clr_start) begin
         exp_to = 1'b0;
         exp_pw = 1'b0;
      end
      if (partial) exp_pw = 1'b1;
      clear_strobes();
      IO_Address    = $urandom;
      IO_Write_Data = $urandom;
      check("cyc_start", {WB_CYC, WB_STB, WB_WE}, {1'b1, 1'b1, wr});
      check("wb_addr", WB_ADDR, addr[31:2]);
      if (wr) check("wb_wdata", WB_DAT_W, wdata);
      check("flags_start", {TIMEOUT_FLAG, PARTIAL_WR_FLAG}, {exp_to, exp_pw});

      while (WB_CYC && high < TO + 4) begin
         if (!(WB_STB && WB_ADDR == addr[31:2] && WB_WE == wr && (!wr || WB_DAT_W == wdata) && !IO_Ready))
            stable = 1'b0;
         WB_ACK   = (high == waits);
         WB_DAT_R = (high == waits) ? rdata : $urandom;
         if (busy && high == 0) begin
            IO_Addr_Strobe  = 1'b1;
            IO_Read_Strobe  = 1'b1;
            IO_Write_Strobe = 1'($urandom);
         end
         if (clr_end && high == exp_high - 1) FLAG_CLR = 1'b1;
         high++;
         tick();
         if (FLAG_CLR) begin
            exp_to = 1'b0;
            exp_pw = 1'b0;
         end
         if (timeout && high == exp_high) exp_to = 1'b1;
         clear_strobes();
         WB_ACK = 1'b0;
         readies += int'(IO_Ready);
      end

      if (rd && !wr) exp_rd = timeout ? TO_DATA : rdata;
      check("cyc_len", high, exp_high);
      check("ready", IO_Ready, 1'b1);
      check("rdata", IO_Read_Data, exp_rd);
      check("flags_end", {TIMEOUT_FLAG, PARTIAL_WR_FLAG}, {exp_to, exp_pw});
      check("bus_stable", stable, 1'b1);

      // DONE cycle: late ACKs and new strobes must both be dropped.
      WB_ACK   = timeout ? 1'b1 : 1'($urandom);
      WB_DAT_R = $urandom;
      if (busy) begin
         IO_Addr_Strobe = 1'b1;
         IO_Read_Strobe = 1'b1;
      end
      tick();
      clear_strobes();
      WB_ACK = 1'b0;
      readies += int'(IO_Ready);
      check("done", {WB_CYC, IO_Ready}, 2'b00);
      check("done_rdata", IO_Read_Data, exp_rd);
      if (busy) begin
         tick();
         readies += int'(IO_Ready);
         check("busy_ignored", {WB_CYC, IO_Ready}, 2'b00);
      end
      check("ready_count", readies, 1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      #1 RST = 1'b0;
      for (int i = 0; i < 5; i++) begin
         IO_Addr_Strobe  = 1'($urandom);
         IO_Read_Strobe  = 1'($urandom);
         IO_Write_Strobe = 1'($urandom);
         IO_Address      = $urandom;
         IO_Write_Data   = $urandom;
         WB_ACK          = 1'($urandom);
         WB_DAT_R        = $urandom;
         tick();
         check("reset_ctrl", {WB_CYC, WB_STB, WB_WE, IO_Ready, TIMEOUT_FLAG, PARTIAL_WR_FLAG}, 6'b0);
         check("reset_data", {WB_ADDR, WB_DAT_W}, 62'b0);
         check("reset_rdata", IO_Read_Data, 32'b0);
      end
      clear_strobes();
      WB_ACK = 1'b0;
      RST    = 1'b1;
      for (int i = 0; i < 3; i++) idle_cycle(1'b0);

      access(1'b1, 1'b0, 32'hC000_0010, 4'hF, 32'h0, 0, 32'h1234_5678, 1'b0, 1'b0, 1'b0);
      access(1'b0, 1'b1, 32'h4000_0100, 4'hF, 32'hA5A5_0001, 3, 32'h0, 1'b0, 1'b0, 1'b0);
      access(1'b1, 1'b0, 32'h8000_0020, 4'hF, 32'h0, -1, 32'h0, 1'b0, 1'b0, 1'b0);
      idle_cycle(1'b1);
      access(1'b0, 1'b1, 32'h0000_0044, 4'b0011, 32'h5555_AAAA, 1, 32'h0, 1'b1, 1'b0, 1'b0);
      access(1'b0, 1'b1, 32'h0000_0048, 4'b1000, 32'h0BAD_F00D, 0, 32'h0, 1'b0, 1'b1, 1'b0);
      access(1'b1, 1'b0, 32'h0000_004C, 4'hF, 32'h0, -1, 32'h0, 1'b0, 1'b0, 1'b1);
      access(1'b1, 1'b0, 32'h0000_0050, 4'hF, 32'h0, TO - 1, 32'hCAFE_0001, 1'b0, 1'b0, 1'b0);
      access(1'b1, 1'b1, 32'h0000_0054, 4'hF, 32'h7777_0000, 2, 32'h1111_2222, 1'b0, 1'b0, 1'b0);

      for (int n = 0; n < 60; n++) begin
         int          kind  = $urandom_range(0, 2);
         int          sel   = $urandom_range(0, 9);
         int          waits = (sel == 9) ? -1 : (sel == 8) ? $urandom_range(TO - 1, TO + 3) : $urandom_range(0, 3);
         logic [3:0]  be    = ($urandom_range(0, 1) == 0) ? 4'hF : 4'($urandom);
         logic [31:0] addr  = $urandom;
         logic [31:0] wdata = $urandom;
         logic [31:0] rdata = $urandom;
         access(kind != 1, kind != 0, addr, be, wdata, waits, rdata,
                $urandom_range(0, 4) == 0, $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0);
         for (int g = $urandom_range(0, 2); g > 0; g--) idle_cycle($urandom_range(0, 3) == 0);
      end

      // Make every sticky/data register non-zero before the mid-cycle reset.
      access(1'b1, 1'b0, 32'h9000_0000, 4'hF, 32'h0, -1, 32'h0, 1'b0, 1'b0, 1'b0);
      access(1'b0, 1'b1, 32'h9000_0004, 4'b0001, 32'hFEED_BEEF, 0, 32'h0, 1'b0, 1'b0, 1'b0);
      IO_Addr_Strobe = 1'b1;
      IO_Read_Strobe = 1'b1;
      IO_Address     = 32'h8000_0040;
      tick();
      clear_strobes();
      check("pre_rst_cyc", WB_CYC, 1'b1);
      tick();
      tick();
      #2 RST = 1'b0;
      #1;
      exp_rd = '0;
      exp_to = 1'b0;
      exp_pw = 1'b0;
      check("async_rst_bus", {WB_CYC, WB_STB, WB_WE, IO_Ready}, 4'b0);
      check("async_rst_data", {WB_ADDR, WB_DAT_W}, 62'b0);
      check("async_rst_misc", {IO_Read_Data, TIMEOUT_FLAG, PARTIAL_WR_FLAG}, 34'b0);
      WB_ACK = 1'b1;
      for (int i = 0; i < 2; i++) begin
         tick();
         check("rst_no_ready", {WB_CYC, IO_Ready}, 2'b00);
      end
      WB_ACK = 1'b0;
      RST    = 1'b1;
      idle_cycle(1'b0);
      access(1'b1, 1'b0, 32'h8000_0040, 4'hF, 32'h0, 1, 32'h600D_DA7A, 1'b0, 1'b0, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
